// File: rtl/tdc_pkg.sv
// Shared constants, FSM encodings and helpers for the TDC host command receiver.
package tdc_pkg;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam logic [7:0] CMD_NOP         = 8'h00;
    localparam logic [7:0] CMD_ARM         = 8'h01;
    localparam logic [7:0] CMD_SET_RATE    = 8'h02;
    localparam logic [7:0] CMD_RESET_STATS = 8'h03;

    typedef enum logic [2:0] {
        B_IDLE  = 3'd0,
        B_START = 3'd1,
        B_DATA  = 3'd2,
        B_STOP  = 3'd3,
        B_BREAK = 3'd4
    } byte_state_t;

    typedef enum logic [2:0] {
        P_SYNC = 3'd0,
        P_CMD  = 3'd1,
        P_ARGH = 3'd2,
        P_ARGL = 3'd3,
        P_CHK  = 3'd4
    } parser_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF input synchronizer plus start/data/stop/break FSM.
// Emits a one-cycle byte strobe on a good stop bit, or a frame error pulse on a low one.
module uart_rx_byte
    import tdc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        i_rx,
    output logic        o_byte_strobe,
    output logic [7:0]  o_byte_data,
    output logic        o_frame_err,
    output byte_state_t o_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_sync;
    logic             w_rx;
    byte_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_strobe;
    logic             r_ferr;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], i_rx};
    end

    assign w_rx = r_sync[1];

    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            r_state   <= B_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_strobe  <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
            case (r_state)
                B_IDLE: begin
                    if (!w_rx) begin
                        r_state <= B_START;
                        r_cnt   <= '0;
                    end
                end
                B_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx ? B_IDLE : B_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_state <= B_STOP;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_strobe <= 1'b1;
                            r_state  <= B_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= B_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Line held low after a bad stop bit: ignore it until it idles high again.
                B_BREAK: begin
                    if (w_rx) r_state <= B_IDLE;
                end
                default: r_state <= B_IDLE;
            endcase
        end
    end

    assign o_byte_strobe = r_strobe;
    assign o_byte_data   = r_shift;
    assign o_frame_err   = r_ferr;
    assign o_state       = r_state;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host->FPGA command receiver: parses A5,CMD,ARG_H,ARG_L,CHK frames (CHK = CMD^ARG_H^ARG_L).
// Optional inter-byte timeout is built only when CMD_RX_TIMEOUT_EN is defined.
module uart_cmd_rx
    import tdc_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
`ifdef CMD_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CLKS = CLK_FREQ / 100
`endif
) (
    input  logic          clk_100m,
    input  logic          rst_n,
    input  logic          uart_rx,
    output logic          cmd_valid,
    output logic [7:0]    cmd,
    output logic [15:0]   arg,
    output logic          frame_err,
    output logic          chk_err,
    output logic          rx_active,
    output byte_state_t   dbg_byte_state,
    output parser_state_t dbg_parser_state
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    logic          w_byte_strobe;
    logic [7:0]    w_byte_data;
    logic          w_frame_err;
    byte_state_t   w_byte_state;

    parser_state_t r_state;
    logic [7:0]    r_cmd_stage;
    logic [7:0]    r_argh;
    logic [7:0]    r_argl;
    logic [7:0]    r_chk;
    logic [7:0]    r_cmd;
    logic [15:0]   r_arg;
    logic          r_cmd_valid;
    logic          r_chk_err;

`ifdef CMD_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS - 1);
    logic [TO_W-1:0] r_to_cnt;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk_100m      (clk_100m),
        .rst_n         (rst_n),
        .i_rx          (uart_rx),
        .o_byte_strobe (w_byte_strobe),
        .o_byte_data   (w_byte_data),
        .o_frame_err   (w_frame_err),
        .o_state       (w_byte_state)
    );

    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            r_state     <= P_SYNC;
            r_cmd_stage <= '0;
            r_argh      <= '0;
            r_argl      <= '0;
            r_chk       <= '0;
            r_cmd       <= '0;
            r_arg       <= '0;
            r_cmd_valid <= 1'b0;
            r_chk_err   <= 1'b0;
`ifdef CMD_RX_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            r_chk_err   <= 1'b0;
`ifdef CMD_RX_TIMEOUT_EN
            if (w_byte_strobe || r_state == P_SYNC) r_to_cnt <= '0;
            else                                    r_to_cnt <= r_to_cnt + 1'b1;
`endif
            // A bad stop bit means we may have lost byte alignment: drop the partial frame.
            if (w_frame_err) begin
                r_state <= P_SYNC;
            end
`ifdef CMD_RX_TIMEOUT_EN
            else if (!w_byte_strobe && r_to_cnt == TO_LIMIT) begin
                r_state <= P_SYNC;
            end
`endif
            else if (w_byte_strobe) begin
                case (r_state)
                    P_SYNC: begin
                        if (w_byte_data == SYNC_BYTE) begin
                            r_state <= P_CMD;
                            r_chk   <= '0;
                        end
                    end
                    P_CMD: begin
                        r_cmd_stage <= w_byte_data;
                        r_chk       <= r_chk ^ w_byte_data;
                        r_state     <= P_ARGH;
                    end
                    P_ARGH: begin
                        r_argh  <= w_byte_data;
                        r_chk   <= r_chk ^ w_byte_data;
                        r_state <= P_ARGL;
                    end
                    P_ARGL: begin
                        r_argl  <= w_byte_data;
                        r_chk   <= r_chk ^ w_byte_data;
                        r_state <= P_CHK;
                    end
                    P_CHK: begin
                        if (w_byte_data == r_chk) begin
                            r_cmd       <= r_cmd_stage;
                            r_arg       <= {r_argh, r_argl};
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_chk_err <= 1'b1;
                        end
                        r_state <= P_SYNC;
                    end
                    default: r_state <= P_SYNC;
                endcase
            end
        end
    end

    assign cmd_valid        = r_cmd_valid;
    assign cmd              = r_cmd;
    assign arg              = r_arg;
    assign chk_err          = r_chk_err;
    assign frame_err        = w_frame_err;
    assign rx_active        = (r_state != P_SYNC) || (w_byte_state != B_IDLE);
    assign dbg_byte_state   = w_byte_state;
    assign dbg_parser_state = r_state;

endmodule
